// File: rtl/process_loader_if.sv
// Bundle between the process loader and its neighbours: start/operand bus, source
// read port, RAM write port and RAM offset-change port.
interface process_loader_if #(
    parameter int LEN_W = 12,
    parameter int SRC_W = 16
);
    logic             start;
    logic [11:0]      proc_base;
    logic [SRC_W-1:0] src_base;
    logic [LEN_W-1:0] len;
    logic             run_after;
    logic [SRC_W-1:0] src_addr;
    logic             src_rd;
    logic [31:0]      src_data;
    logic [31:0]      ram_data;
    logic [11:0]      ram_addr;
    logic             ram_mW;
    logic [31:0]      ProcessOffset;
    logic             OffsetChange;
    logic             busy;
    logic             done;

    modport master (
        input  start, proc_base, src_base, len, run_after, src_data,
        output src_addr, src_rd, ram_data, ram_addr, ram_mW,
               ProcessOffset, OffsetChange, busy, done
    );

    modport slave (
        output start, proc_base, src_base, len, run_after, src_data,
        input  src_addr, src_rd, ram_data, ram_addr, ram_mW,
               ProcessOffset, OffsetChange, busy, done
    );
endinterface

// File: rtl/process_loader.sv
// Copies len source words into a process RAM region: set offset, fetch/write each
// word, then leave the offset at the region base or back at 0.
module process_loader #(
    parameter int LEN_W = 12,
    parameter int SRC_W = 16
) (
    input logic             clk,
    input logic             rst,
    process_loader_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETOFF, FETCH, WRITE, FINOFF, DONE} state_t;

    state_t           state, state_nxt;
    logic [11:0]      base, base_nxt;
    logic [SRC_W-1:0] sbase, sbase_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [LEN_W-1:0] i, i_nxt, i_inc;
    logic             run, run_nxt;
    logic [SRC_W-1:0] src_addr_nxt;
    logic [11:0]      ram_addr_nxt;
    logic [31:0]      off_nxt;

    always_comb begin
        state_nxt    = state;
        base_nxt     = base;
        sbase_nxt    = sbase;
        cnt_nxt      = cnt;
        run_nxt      = run;
        i_nxt        = i;
        i_inc        = i + LEN_W'(1);
        src_addr_nxt = bus.src_addr;
        ram_addr_nxt = bus.ram_addr;
        off_nxt      = bus.ProcessOffset;

        case (state)
            IDLE: if (bus.start) begin
                base_nxt  = bus.proc_base;
                sbase_nxt = bus.src_base;
                cnt_nxt   = bus.len;
                run_nxt   = bus.run_after;
                i_nxt     = '0;
                state_nxt = SETOFF;
            end
            SETOFF: state_nxt = (cnt != '0) ? FETCH : FINOFF;
            FETCH:  state_nxt = WRITE;
            WRITE: begin
                i_nxt     = i_inc;
                state_nxt = (i_inc < cnt) ? FETCH : FINOFF;
            end
            FINOFF: state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered, so decode them from the state being entered.
        case (state_nxt)
            SETOFF: off_nxt      = {20'b0, base_nxt};
            FETCH:  src_addr_nxt = sbase_nxt + SRC_W'(i_nxt);
            WRITE:  ram_addr_nxt = 12'(i_nxt);
            FINOFF: off_nxt      = run_nxt ? {20'b0, base_nxt} : 32'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            base              <= '0;
            sbase             <= '0;
            cnt               <= '0;
            run               <= 1'b0;
            i                 <= '0;
            bus.src_addr      <= '0;
            bus.src_rd        <= 1'b0;
            bus.ram_addr      <= '0;
            bus.ram_mW        <= 1'b0;
            bus.ProcessOffset <= '0;
            bus.OffsetChange  <= 1'b0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
        end else begin
            state             <= state_nxt;
            base              <= base_nxt;
            sbase             <= sbase_nxt;
            cnt               <= cnt_nxt;
            run               <= run_nxt;
            i                 <= i_nxt;
            bus.src_addr      <= src_addr_nxt;
            bus.src_rd        <= (state_nxt == FETCH);
            bus.ram_addr      <= ram_addr_nxt;
            bus.ram_mW        <= (state_nxt == WRITE);
            bus.ProcessOffset <= off_nxt;
            bus.OffsetChange  <= (state_nxt == SETOFF) || (state_nxt == FINOFF);
            bus.busy          <= (state_nxt != IDLE);
            bus.done          <= (state_nxt == DONE);
        end
    end

    // Source data arrives the cycle after FETCH and goes straight through.
    assign bus.ram_data = (state == WRITE) ? bus.src_data : 32'b0;
endmodule

// File: tb/tb_process_loader.sv
// Scoreboard bench for process_loader: expected offsets, source reads and RAM
// writes are queued at start and popped by a negedge monitor.
module tb_process_loader;
    localparam int LEN_W = 12;
    localparam int SRC_W = 16;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    process_loader_if #(.LEN_W(LEN_W), .SRC_W(SRC_W)) bus ();
    process_loader #(.LEN_W(LEN_W), .SRC_W(SRC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    wr_t              exp_wr[$];
    logic [31:0]      exp_off[$];
    logic [SRC_W-1:0] exp_src[$];
    int n_chk = 0, n_fail = 0, n_wr = 0, n_rd = 0;
    logic [31:0] ram_off = 32'b0;
    logic [31:0] ref_ram[int];

    function automatic logic [31:0] src_word(input logic [SRC_W-1:0] a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    // Source memory: one-cycle read latency.
    always @(posedge clk) bus.src_data <= bus.src_rd ? src_word(bus.src_addr) : 32'h0BAD_0BAD;

    initial begin
        wr_t w;
        logic [31:0] o;
        logic [SRC_W-1:0] a;
        forever begin
            @(negedge clk);
            if (bus.src_rd === 1'b1) begin
                n_rd++; n_chk++;
                if (exp_src.size() == 0) begin
                    n_fail++; $display("FAIL src_rd unexpected: addr=%h", bus.src_addr);
                end else begin
                    a = exp_src.pop_front();
                    if (bus.src_addr !== a) begin
                        n_fail++; $display("FAIL src_addr: got %h want %h", bus.src_addr, a);
                    end
                end
            end
            if (bus.ram_mW === 1'b1) begin
                n_wr++; n_chk++;
                ref_ram[int'(ram_off) + int'(bus.ram_addr)] = bus.ram_data;
                if (exp_wr.size() == 0) begin
                    n_fail++; $display("FAIL ram_write unexpected: addr=%h data=%h", bus.ram_addr, bus.ram_data);
                end else begin
                    w = exp_wr.pop_front();
                    if (bus.ram_addr !== w.addr || bus.ram_data !== w.data) begin
                        n_fail++;
                        $display("FAIL ram_write: got %h/%h want %h/%h", bus.ram_addr, bus.ram_data, w.addr, w.data);
                    end
                end
            end
            if (bus.OffsetChange === 1'b1) begin
                n_chk++;
                ram_off = bus.ProcessOffset;
                if (exp_off.size() == 0) begin
                    n_fail++; $display("FAIL offset unexpected: %h", bus.ProcessOffset);
                end else begin
                    o = exp_off.pop_front();
                    if (bus.ProcessOffset !== o) begin
                        n_fail++; $display("FAIL offset: got %h want %h", bus.ProcessOffset, o);
                    end
                end
            end
            if ($countones({bus.src_rd === 1'b1, bus.ram_mW === 1'b1, bus.OffsetChange === 1'b1}) > 1) begin
                n_chk++; n_fail++;
                $display("FAIL strobe_excl: rd=%b mW=%b oc=%b", bus.src_rd, bus.ram_mW, bus.OffsetChange);
            end
        end
    end

    function automatic void push_exp(input logic [11:0] pb, input logic [SRC_W-1:0] sb,
                                     input int ln, input logic ra);
        wr_t w;
        exp_off.push_back({20'b0, pb});
        for (int k = 0; k < ln; k++) begin
            exp_src.push_back(sb + SRC_W'(k));
            w.addr = 12'(k);
            w.data = src_word(sb + SRC_W'(k));
            exp_wr.push_back(w);
        end
        exp_off.push_back(ra ? {20'b0, pb} : 32'b0);
    endfunction

    task automatic start_load(input logic [11:0] pb, input logic [SRC_W-1:0] sb,
                              input int ln, input logic ra);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.proc_base = pb; bus.src_base = sb;
        bus.len = LEN_W'(ln); bus.run_after = ra;
        push_exp(pb, sb, ln, ra);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Returns the cycle (start cycle = 0) in which done is seen, or -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 20000; c++) begin
            if (bus.done === 1'b1) begin lat = c; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        int cnt;
        logic seen_done;
        @(posedge clk); @(posedge clk); #1;
        n_chk++;
        if ({bus.src_addr, bus.ram_data, bus.ram_addr, bus.ProcessOffset, bus.src_rd, bus.ram_mW,
             bus.OffsetChange, bus.busy, bus.done} !== '0) begin
            n_fail++; $display("FAIL reset_state: addr=%h data=%h ra=%h off=%h strobes=%b%b%b busy=%b done=%b",
                bus.src_addr, bus.ram_data, bus.ram_addr, bus.ProcessOffset, bus.src_rd, bus.ram_mW,
                bus.OffsetChange, bus.busy, bus.done);
        end
        rst = 1'b1;
        start_load(12'h200, 16'h0040, 8, 1'b1);
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 3; c++) begin
            if (bus.ram_mW === 1'b1) cnt++;
            if (cnt == 3) rst = 1'b0;
            else begin @(posedge clk); #1; end
        end
        n_chk++;
        if (cnt != 3) begin n_fail++; $display("FAIL reset_third_write: saw %0d writes want 3", cnt); end
        @(posedge clk); #1;
        n_chk++;
        if ({bus.src_addr, bus.ram_data, bus.ram_addr, bus.ProcessOffset, bus.src_rd, bus.ram_mW,
             bus.OffsetChange, bus.busy, bus.done} !== '0) begin
            n_fail++; $display("FAIL reset_abort: addr=%h data=%h ra=%h off=%h strobes=%b%b%b busy=%b done=%b",
                bus.src_addr, bus.ram_data, bus.ram_addr, bus.ProcessOffset, bus.src_rd, bus.ram_mW,
                bus.OffsetChange, bus.busy, bus.done);
        end
        rst = 1'b1;
        exp_wr.delete(); exp_off.delete(); exp_src.delete();
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done = 1'b1;
        end
        n_chk++;
        if (seen_done) begin n_fail++; $display("FAIL reset_no_done: done/busy seen after abort, want idle"); end
    endtask

    task automatic test_basic();
        int lat;
        start_load(12'h100, 16'h0020, 4, 1'b1);
        n_chk++;
        if (bus.OffsetChange !== 1'b1 || bus.ProcessOffset !== 32'h100 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_setoff: oc=%b off=%h busy=%b want 1/100/1",
                bus.OffsetChange, bus.ProcessOffset, bus.busy);
        end
        wait_done(lat);
        n_chk++;
        if (lat != 11) begin n_fail++; $display("FAIL basic_latency: got %0d want 11", lat); end
        @(posedge clk); #1;
        n_chk++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle: busy=%b done=%b want 0/0", bus.busy, bus.done);
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (!ref_ram.exists(32'h100 + k) || ref_ram[32'h100 + k] !== 32'hA000_0020 + k) begin
                n_fail++; $display("FAIL basic_ram[%0h]: present=%0d want %h", 32'h100 + k,
                    ref_ram.exists(32'h100 + k), 32'hA000_0020 + k);
            end
        end
        n_chk++;
        if (exp_wr.size() + exp_off.size() + exp_src.size() != 0) begin
            n_fail++; $display("FAIL basic_leftover: %0d expectations unmet want 0",
                exp_wr.size() + exp_off.size() + exp_src.size());
        end
    endtask

    task automatic test_run_after0();
        int lat;
        start_load(12'h3F0, 16'h0010, 2, 1'b0);
        wait_done(lat);
        n_chk++;
        if (lat != 7) begin n_fail++; $display("FAIL ra0_latency: got %0d want 7", lat); end
        n_chk++;
        if (ram_off !== 32'h0 || exp_off.size() != 0 || exp_wr.size() != 0) begin
            n_fail++; $display("FAIL ra0_offset: ram_off=%h left=%0d want 0/0", ram_off, exp_off.size() + exp_wr.size());
        end
    endtask

    task automatic test_len0();
        int lat, rd0, wr0;
        rd0 = n_rd; wr0 = n_wr;
        start_load(12'h055, 16'h0000, 0, 1'b1);
        wait_done(lat);
        n_chk++;
        if (lat != 3) begin n_fail++; $display("FAIL len0_latency: got %0d want 3", lat); end
        n_chk++;
        if (n_rd != rd0 || n_wr != wr0) begin
            n_fail++; $display("FAIL len0_strobes: rd=%0d wr=%0d want 0/0", n_rd - rd0, n_wr - wr0);
        end
    endtask

    task automatic test_busy_reject();
        int lat, wr0;
        logic extra;
        wr0 = n_wr; lat = -1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.proc_base = 12'h0A0; bus.src_base = 16'h0300;
        bus.len = LEN_W'(3); bus.run_after = 1'b1;
        push_exp(12'h0A0, 16'h0300, 3, 1'b1);
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin lat = c; bus.start = 1'b0; break; end
            bus.start = 1'b1;
            bus.proc_base = 12'($urandom); bus.src_base = 16'($urandom);
            bus.len = LEN_W'($urandom_range(1, 20)); bus.run_after = 1'($urandom);
        end
        bus.start = 1'b0;
        extra = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra = 1'b1;
        end
        n_chk++;
        if (lat != 9) begin n_fail++; $display("FAIL busy_latency: got %0d want 9", lat); end
        n_chk++;
        if (n_wr - wr0 != 3) begin n_fail++; $display("FAIL busy_writes: got %0d want 3", n_wr - wr0); end
        n_chk++;
        if (extra) begin n_fail++; $display("FAIL busy_idle: busy/done after completion, want idle"); end
    endtask

    task automatic test_wrap();
        int lat;
        start_load(12'h010, 16'hFFFE, 4, 1'b1);
        wait_done(lat);
        n_chk++;
        if (lat != 11) begin n_fail++; $display("FAIL wrap_latency: got %0d want 11", lat); end
        n_chk++;
        if (exp_src.size() != 0) begin n_fail++; $display("FAIL wrap_reads: %0d missing want 0", exp_src.size()); end
    endtask

    task automatic test_max_len();
        int lat, wr0;
        wr0 = n_wr;
        start_load(12'h000, 16'h1000, 4095, 1'b0);
        wait_done(lat);
        n_chk++;
        if (lat != 8193) begin n_fail++; $display("FAIL maxlen_latency: got %0d want 8193", lat); end
        n_chk++;
        if (n_wr - wr0 != 4095) begin n_fail++; $display("FAIL maxlen_writes: got %0d want 4095", n_wr - wr0); end
        n_chk++;
        if (!ref_ram.exists(4094) || ref_ram[4094] !== src_word(16'h1000 + 16'd4094)) begin
            n_fail++; $display("FAIL maxlen_last: present=%0d want %h", ref_ram.exists(4094), src_word(16'h1000 + 16'd4094));
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.proc_base = '0; bus.src_base = '0; bus.len = '0; bus.run_after = 1'b0;
        test_reset();
        test_basic();
        test_run_after0();
        test_len0();
        test_busy_reject();
        test_wrap();
        test_max_len();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
